// File: rtl/store_rmw_ctrl.sv
// Store sequencer for the MEM stage: SW writes straight through, SB/SH do a
// read-modify-write of the containing word with a little-endian lane merge.
module store_rmw_ctrl #(
  parameter int unsigned READ_LATENCY = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_data,
  input  logic [1:0]  req_type,
  output logic        req_ready,
  output logic        stall,
  output logic        misalign,
  output logic        done,
  output logic [31:0] mem_addr,
  output logic        mem_re,
  input  logic [31:0] mem_rdata,
  output logic        mem_we,
  output logic [31:0] mem_wdata
);

  typedef enum logic [1:0] {IDLE, RD_WAIT, WRITE} state_t;

  localparam logic [2:0] LAT = 3'(READ_LATENCY);

  state_t      state_reg, state_next;
  logic [2:0]  cnt_reg;
  logic [1:0]  off_reg;
  logic        half_reg;
  logic [15:0] data_reg;
  logic [31:0] mem_addr_reg;
  logic [31:0] mem_wdata_reg;
  logic [31:0] merged;
  logic        accept;

  // Types 2 and 3 both behave as SW, so req_type[1] selects the direct-write path.
  always_comb begin
    misalign = 1'b0;
    if (state_reg == IDLE && req_valid) begin
      case (req_type)
        2'd0:    misalign = 1'b0;
        2'd1:    misalign = req_addr[0];
        default: misalign = |req_addr[1:0];
      endcase
    end
  end

  assign accept = (state_reg == IDLE) && req_valid && !misalign;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (accept) begin
          state_next = req_type[1] ? WRITE : RD_WAIT;
        end
      end
      RD_WAIT: begin
        if (cnt_reg == 3'd0) begin
          state_next = WRITE;
        end
      end
      WRITE:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    merged = mem_rdata;
    if (!half_reg) begin
      case (off_reg)
        2'd0: merged[7:0]   = data_reg[7:0];
        2'd1: merged[15:8]  = data_reg[7:0];
        2'd2: merged[23:16] = data_reg[7:0];
        2'd3: merged[31:24] = data_reg[7:0];
        default: merged = mem_rdata;
      endcase
    end else if (off_reg[1]) begin
      merged[31:16] = data_reg;
    end else begin
      merged[15:0] = data_reg;
    end
  end

  // The counter equals LAT only in the first RD_WAIT cycle, which is where the read strobe goes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg       <= 3'd0;
      off_reg       <= 2'd0;
      half_reg      <= 1'b0;
      data_reg      <= 16'd0;
      mem_addr_reg  <= 32'd0;
      mem_wdata_reg <= 32'd0;
    end else if (accept) begin
      mem_addr_reg <= {req_addr[31:2], 2'b00};
      off_reg      <= req_addr[1:0];
      half_reg     <= req_type[0];
      data_reg     <= req_data[15:0];
      if (req_type[1]) begin
        mem_wdata_reg <= req_data;
      end else begin
        cnt_reg <= LAT;
      end
    end else if (state_reg == RD_WAIT) begin
      if (cnt_reg == 3'd0) begin
        mem_wdata_reg <= merged;
      end else begin
        cnt_reg <= cnt_reg - 3'd1;
      end
    end
  end

  always_comb begin
    req_ready = (state_reg == IDLE);
    stall     = accept || (state_reg == RD_WAIT);
    mem_re    = (state_reg == RD_WAIT) && (cnt_reg == LAT);
    mem_we    = (state_reg == WRITE);
    done      = (state_reg == WRITE);
    mem_addr  = mem_addr_reg;
    mem_wdata = mem_wdata_reg;
  end

endmodule

// File: tb/tb_store_rmw_ctrl.sv
// Bench for store_rmw_ctrl: one instance at read latency 1, one at latency 3,
// each backed by a small word memory; expected writes are queued at issue time.
module tb_store_rmw_ctrl;

  localparam int NI = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        req_valid [NI];
  logic [31:0] req_addr  [NI];
  logic [31:0] req_data  [NI];
  logic [1:0]  req_type  [NI];
  logic        req_ready [NI];
  logic        stall     [NI];
  logic        misalign  [NI];
  logic        done      [NI];
  logic [31:0] mem_addr  [NI];
  logic        mem_re    [NI];
  logic [31:0] mem_rdata [NI];
  logic        mem_we    [NI];
  logic [31:0] mem_wdata [NI];

  logic [31:0] mem [NI][1024];
  logic        pre_we = 1'b0;
  int          pre_i = 0;
  int          pre_w = 0;
  logic [31:0] pre_d = 32'd0;

  int cyc = 0;
  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    int          inst;
    logic [31:0] addr;
    logic [31:0] data;
    int          re_cyc;
    int          we_cyc;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;

  store_rmw_ctrl #(.READ_LATENCY(1)) dut_l1 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid[0]), .req_addr(req_addr[0]), .req_data(req_data[0]),
    .req_type(req_type[0]), .req_ready(req_ready[0]), .stall(stall[0]),
    .misalign(misalign[0]), .done(done[0]), .mem_addr(mem_addr[0]),
    .mem_re(mem_re[0]), .mem_rdata(mem_rdata[0]), .mem_we(mem_we[0]),
    .mem_wdata(mem_wdata[0])
  );

  store_rmw_ctrl #(.READ_LATENCY(3)) dut_l3 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid[1]), .req_addr(req_addr[1]), .req_data(req_data[1]),
    .req_type(req_type[1]), .req_ready(req_ready[1]), .stall(stall[1]),
    .misalign(misalign[1]), .done(done[1]), .mem_addr(mem_addr[1]),
    .mem_re(mem_re[1]), .mem_rdata(mem_rdata[1]), .mem_we(mem_we[1]),
    .mem_wdata(mem_wdata[1])
  );

  assign mem_rdata[0] = mem[0][mem_addr[0][11:2]];
  assign mem_rdata[1] = mem[1][mem_addr[1][11:2]];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    for (int i = 0; i < NI; i++) begin
      if (mem_we[i]) mem[i][mem_addr[i][11:2]] = mem_wdata[i];
    end
    if (pre_we) mem[pre_i][pre_w] = pre_d;
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Monitor: every read strobe and write must match the head of the scoreboard.
  always @(negedge clk) begin
    for (int i = 0; i < NI; i++) begin
      if (rst_n && mem_re[i]) begin
        check_eq("re_stall", 32'(stall[i]), 32'd1);
        if (sb_q.size() == 0) check_eq("re_unexpected", 32'(mem_re[i]), 32'd0);
        else check_eq("re_cycle", cyc, sb_q[0].re_cyc);
      end
      if (mem_we[i] || done[i]) begin
        check_eq("done_with_we", 32'(done[i]), 32'(mem_we[i]));
        check_eq("we_stall", 32'(stall[i]), 32'd0);
        if (sb_q.size() == 0) begin
          check_eq("we_unexpected", 32'(mem_we[i]), 32'd0);
        end else begin
          mon_e = sb_q.pop_front();
          check_eq("we_inst", i, mon_e.inst);
          check_eq("we_cycle", cyc, mon_e.we_cyc);
          check_eq("we_addr", mem_addr[i], mon_e.addr);
          check_eq("we_data", mem_wdata[i], mon_e.data);
          $display("inst %0d write addr 0x%08h data 0x%08h cycle %0d", i, mem_addr[i], mem_wdata[i], cyc);
        end
      end
    end
  end

  task automatic preload(input int i, input int w, input logic [31:0] d);
    pre_i = i; pre_w = w; pre_d = d; pre_we = 1'b1;
    @(negedge clk);
    pre_we = 1'b0;
  endtask

  // Called at a falling edge with the DUT idle; returns at the falling edge of cycle 1.
  task automatic do_store(input int i, input logic [1:0] t, input logic [31:0] a,
                          input logic [31:0] d, input logic [31:0] w);
    exp_t e;
    int lat;
    lat = (i == 0) ? 1 : 3;
    req_valid[i] = 1'b1; req_type[i] = t; req_addr[i] = a; req_data[i] = d;
    #1;
    check_eq("acc_misalign", 32'(misalign[i]), 32'd0);
    check_eq("acc_stall", 32'(stall[i]), 32'd1);
    check_eq("acc_ready", 32'(req_ready[i]), 32'd1);
    e.inst   = i;
    e.addr   = {a[31:2], 2'b00};
    e.data   = w;
    e.re_cyc = t[1] ? -1 : cyc + 1;
    e.we_cyc = cyc + (t[1] ? 1 : 2 + lat);
    sb_q.push_back(e);
    $display("inst %0d issue type %0d addr 0x%08h data 0x%08h cycle %0d", i, t, a, d, cyc);
    @(negedge clk);
    req_valid[i] = 1'b0;
  endtask

  // Returns at the falling edge of the idle cycle right after the last write.
  task automatic wait_drain();
    int n;
    n = 0;
    while (sb_q.size() != 0 && n < 40) begin
      @(negedge clk);
      #2;
      n++;
    end
    check_eq("drain_timeout", sb_q.size(), 0);
    sb_q.delete();
    @(negedge clk);
  endtask

  task automatic do_misalign(input int i, input logic [1:0] t, input logic [31:0] a);
    req_valid[i] = 1'b1; req_type[i] = t; req_addr[i] = a; req_data[i] = 32'h5A5A5A5A;
    #1;
    check_eq("mis_flag", 32'(misalign[i]), 32'd1);
    check_eq("mis_stall", 32'(stall[i]), 32'd0);
    $display("inst %0d misaligned type %0d addr 0x%08h cycle %0d", i, t, a, cyc);
    @(negedge clk);
    req_valid[i] = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check_eq("mis_ready", 32'(req_ready[i]), 32'd1);
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    for (int i = 0; i < NI; i++) begin
      req_valid[i] = 1'b0; req_addr[i] = 32'd0; req_data[i] = 32'd0; req_type[i] = 2'd0;
    end
    @(negedge clk);
    preload(0, 32'h100 >> 2, 32'h11223344);
    preload(0, 32'h400 >> 2, 32'h55667788);
    preload(1, 32'h010 >> 2, 32'h00000000);
    preload(1, 32'h020 >> 2, 32'h00000000);
    #1;
    for (int i = 0; i < NI; i++) begin
      check_eq("rst_ready", 32'(req_ready[i]), 32'd1);
      check_eq("rst_stall", 32'(stall[i]), 32'd0);
      check_eq("rst_misalign", 32'(misalign[i]), 32'd0);
      check_eq("rst_re", 32'(mem_re[i]), 32'd0);
      check_eq("rst_we", 32'(mem_we[i]), 32'd0);
      check_eq("rst_done", 32'(done[i]), 32'd0);
      check_eq("rst_addr", mem_addr[i], 32'd0);
      check_eq("rst_wdata", mem_wdata[i], 32'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    do_misalign(0, 2'd1, 32'h101);
    do_misalign(0, 2'd2, 32'h102);
    do_misalign(0, 2'd3, 32'h303);

    do_store(0, 2'd0, 32'h102, 32'h000000AB, 32'h11AB3344); wait_drain();
    preload(0, 32'h204 >> 2, 32'hDEADBEEF);
    do_store(0, 2'd1, 32'h206, 32'h00001234, 32'h1234BEEF); wait_drain();
    preload(0, 32'h204 >> 2, 32'hDEADBEEF);
    do_store(0, 2'd1, 32'h204, 32'h00001234, 32'hDEAD1234); wait_drain();
    do_store(0, 2'd2, 32'h300, 32'hCAFEF00D, 32'hCAFEF00D); wait_drain();
    do_store(0, 2'd3, 32'h304, 32'h01020304, 32'h01020304); wait_drain();
    do_store(0, 2'd0, 32'h401, 32'hFFFFFFCD, 32'h5566CD88); wait_drain();
    check_eq("mem_sw", mem[0][32'h300 >> 2], 32'hCAFEF00D);

    // Reset during the read cycle of an SB: everything must drop at once and never write.
    do_store(0, 2'd0, 32'h100, 32'h00000077, 32'h11223377);
    rst_n = 1'b0;
    #1;
    check_eq("mid_rst_re", 32'(mem_re[0]), 32'd0);
    check_eq("mid_rst_we", 32'(mem_we[0]), 32'd0);
    check_eq("mid_rst_stall", 32'(stall[0]), 32'd0);
    check_eq("mid_rst_addr", mem_addr[0], 32'd0);
    sb_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    check_eq("post_rst_ready", 32'(req_ready[0]), 32'd1);
    check_eq("post_rst_stall", 32'(stall[0]), 32'd0);
    repeat (5) @(negedge clk);
    check_eq("mem_untouched", mem[0][32'h100 >> 2], 32'h11AB3344);

    // Latency 3, back-to-back byte stores; the second is presented right after the first write.
    do_store(1, 2'd0, 32'h010, 32'h000000AA, 32'h000000AA); wait_drain();
    do_store(1, 2'd0, 32'h023, 32'h000000BB, 32'hBB000000); wait_drain();
    check_eq("mem_b2b", mem[1][32'h020 >> 2], 32'hBB000000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got 0x%08h, expected 0x%08h", cyc, 0);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/store_rmw_ctrl.md
# store_rmw_ctrl

Memory-stage store sequencer for the pipelined MIPS CPU. Accepts SB/SH/SW requests from the MEM stage, performs a read-modify-write on word-wide data memory for sub-word stores, and a direct write for SW. Little-endian lane merge. Holds the pipeline via `stall` until the write has been issued.

## Interface
Parameters:
- `READ_LATENCY`, 1: cycles from a `mem_re` cycle to valid `mem_rdata`; legal range 1–7.

Ports:
- `clk` in 1: the single clock; all state updates on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `req_valid` in 1: MEM-stage store request present.
- `req_addr` in 32: byte address.
- `req_data` in 32: store data, right-aligned: byte in [7:0], half in [15:0].
- `req_type` in 2: 0 = SB, 1 = SH, 2 = SW, 3 = reserved (handled as SW).
- `req_ready` out 1: high in IDLE.
- `stall` out 1: pipeline hold request to the hazard unit.
- `misalign` out 1: combinational pulse; the request is rejected.
- `done` out 1: one-cycle pulse in the write cycle.
- `mem_addr` out 32: word address, {addr[31:2], 2'b00}.
- `mem_re` out 1: memory read strobe.
- `mem_rdata` in 32: memory read data.
- `mem_we` out 1: memory write strobe.
- `mem_wdata` out 32: merged write word.

## Operation
- States: IDLE, RD_WAIT, WRITE.
- **Accept:** occurs in IDLE when `req_valid` is high and `misalign` is low. Capture addr, data and type into registers.
  - SB/SH: go to RD_WAIT.
  - SW/reserved: latch `req_data` as the write word, then go to WRITE.
- **Misalign:** `misalign` is `req_valid` in IDLE AND one of:
  - SH with addr[0] = 1;
  - SW/reserved with addr[1:0] ≠ 0.
  - On misalign: no accept, no memory access, `stall` low, state stays IDLE.
- **RD_WAIT:**
  - `mem_re` is high only in the first RD_WAIT cycle.
  - A 3-bit counter loads `READ_LATENCY` on entry and decrements each cycle.
  - When the counter reaches 0, sample `mem_rdata`, form the merged word, register it into `mem_wdata`, and go to WRITE.
- **Merge rules** (rd = sampled read word, d = captured data):
  - SB, addr[1:0] = 0: {rd[31:8], d[7:0]}
  - SB, addr[1:0] = 1: {rd[31:16], d[7:0], rd[7:0]}
  - SB, addr[1:0] = 2: {rd[31:24], d[7:0], rd[15:0]}
  - SB, addr[1:0] = 3: {d[7:0], rd[23:0]}
  - SH, addr[1] = 0: {rd[31:16], d[15:0]}
  - SH, addr[1] = 1: {d[15:0], rd[15:0]}
- **WRITE:** `mem_we` = 1 and `done` = 1 for exactly one cycle, then IDLE.
- **Stall:** `stall` = (IDLE & `req_valid` & !`misalign`) | (RD_WAIT) | (WRITE & 0).
  - `stall` is low in the WRITE cycle, so the pipeline advances on that edge.
  - The same store is never re-accepted.
- `mem_addr` is driven from the captured address whenever state ≠ IDLE. In IDLE it holds its last value.
- **Reset:** asynchronous; applies immediately, including mid-operation.
  - State → IDLE.
  - `mem_re`, `mem_we`, `done` → 0.
  - `mem_addr`, `mem_wdata` → 0.
  - Counter → 0.
  - An in-flight write is abandoned; memory is never written with partial data.
- **After reset:** `req_ready` = 1. `stall` and `misalign` are 0 unless `req_valid` is high.

## Timing
- Accept at cycle 0 (IDLE).
- SW: WRITE at cycle 1; total 2 cycles; `stall` high in cycle 0 only.
- SB/SH: `mem_re` at cycle 1, rdata sampled at cycle 1+`READ_LATENCY`, WRITE at cycle 2+`READ_LATENCY`.
  - With the default latency, `mem_we` is at cycle 3.
  - `stall` is high for cycles 0 … 1+`READ_LATENCY`.
- `req_valid` is ignored outside IDLE. The upstream stage holds its request stable while `stall` is high.
- Request in the cycle immediately after WRITE: accepted normally (back-to-back stores, no bubble beyond the above).
- `done` and `mem_we` are registered state decodes: glitch-free and coincident.

## Test plan
- **SB, byte 2:** memory word 0x11223344; SB addr 0x102, data 0x000000AB, L = 1 → `mem_re` at cycle 1; `mem_we` at cycle 3 with addr 0x100, wdata 0x11AB3344; `done` is a single pulse.
- **SH, upper half:** memory word 0xDEADBEEF; SH addr 0x206, data 0x1234 → wdata 0x1234BEEF. SH addr 0x204 → wdata 0xDEAD1234.
- **SW, aligned:** SW addr 0x300, data 0xCAFEF00D → no `mem_re`; `mem_we` at cycle 1 with 0xCAFEF00D; `stall` high only in cycle 0.
- **Misaligned:**
  - SH addr 0x101 → `misalign` = 1 in the same cycle; no `mem_re`/`mem_we`; `stall` = 0.
  - SW addr 0x102 → same response.
- **Reset mid-RMW:** `rst_n` pulled low in the RD_WAIT cycle of an SB → `mem_re`/`mem_we` drop immediately; `mem_we` is never asserted; after release `req_ready` = 1 and the state is IDLE.
- **Latency and back-to-back:** `READ_LATENCY` = 3, two consecutive SB stores to bytes 0 and 3 of 0x00000000 → first write 0x000000AA at cycle 5, second write issued 6 cycles later with 0xBB000000.
